// File: rtl/isa_pkg.sv
// Shared instruction-set constants: the NOP fill word, the boot image and the
// word-index width helper used by the instruction memory.
package isa_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    localparam int unsigned BOOT_WORDS = 8;

    localparam logic [31:0] BOOT_IMAGE [BOOT_WORDS] = '{
        32'h0050_0093,
        32'h00A0_0113,
        32'h0020_81B3,
        32'h4011_0233,
        32'h0020_F2B3,
        32'h0020_E333,
        32'h0030_2023,
        32'h0000_2383
    };

    // Bits needed to index DEPTH words; never narrower than one bit.
    function automatic int unsigned word_idx_width(input int unsigned depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Reset contents of word idx: boot image first, fill word elsewhere.
    function automatic logic [31:0] default_word(input int unsigned idx,
                                                 input logic [31:0] fill);
        logic [31:0] word;
        word = fill;
        if (idx < BOOT_WORDS) begin
            word = BOOT_IMAGE[3'(idx)];
        end
        return word;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction store with combinational fetch, a program-load
// write port and an asynchronous reset back to the boot image.
module instruction_memory #(
    parameter int unsigned DEPTH    = 256,
    parameter logic [31:0] NOP_WORD = isa_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    output logic [31:0] instr,
    output logic        misaligned,
    output logic        out_of_range,
    input  logic        we,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata
);
    import isa_pkg::*;

    localparam int unsigned IW         = word_idx_width(DEPTH);
    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH) * 64'd4;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic          wr_ok;

    assign rd_idx = addr[IW+1:2];
    assign wr_idx = waddr[IW+1:2];

    // Flags are a pure function of the fetch address.
    always_comb begin
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ({32'b0, addr} >= BYTE_LIMIT);
    end

    always_comb begin
        instr = NOP_WORD;
        if (!misaligned && !out_of_range) begin
            instr = mem_q[rd_idx];
        end
    end

    // Misaligned or out-of-range program loads are dropped.
    always_comb begin
        wr_ok = we && (waddr[1:0] == 2'b00) && ({32'b0, waddr} < BYTE_LIMIT);
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_idx] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= default_word(i, NOP_WORD);
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Randomized self-checking bench for instruction_memory against a word-array
// model of the program image.
module tb_instruction_memory;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        misaligned;
    logic        out_of_range;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;

    int checks;
    int errors;

    logic [31:0] model [DEPTH];
    logic [31:0] boot  [8];

    instruction_memory #(
        .DEPTH   (DEPTH),
        .NOP_WORD(NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .instr       (instr),
        .misaligned  (misaligned),
        .out_of_range(out_of_range),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = (i < 8) ? boot[i] : NOP;
    endfunction

    // Expected {instr, misaligned, out_of_range} for a fetch address.
    function automatic logic [33:0] model_read(input logic [31:0] a);
        logic mis;
        logic oor;
        logic [31:0] w;
        mis = (a % 4) != 0;
        oor = a >= DEPTH * 4;
        w   = (mis || oor) ? NOP : model[a / 4];
        return {w, mis, oor};
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        if ((a % 4) == 0 && a < DEPTH * 4) model[a / 4] = d;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
        model_write(a, d);
    endtask

    task automatic test_reset();
        logic [33:0] exp;
        logic [33:0] got;
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; addr = '0;
        model_reset();
        #3;
        // Reads are live while reset is held.
        addr = 32'h8; #1;
        exp = {boot[2], 2'b00}; got = {instr, misaligned, out_of_range};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_hold_read: got %h exp %h", got, exp);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr = 32'(i * 4);
            #10;
            exp = {boot[i], 2'b00}; got = {instr, misaligned, out_of_range};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_image_w%0d: got %h exp %h", i, got, exp);
            end
        end
        addr = 32'h20; #1;
        exp = {NOP, 2'b00}; got = {instr, misaligned, out_of_range};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_fill_w8: got %h exp %h", got, exp);
        end
    endtask

    task automatic test_flags();
        logic [31:0] alist [4];
        logic [33:0] exp;
        logic [33:0] got;
        alist = '{32'h6, 32'h400, 32'h401, 32'hFFFF_FFFC};
        foreach (alist[k]) begin
            addr = alist[k]; #1;
            exp = model_read(alist[k]); got = {instr, misaligned, out_of_range};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL flags_%h: got %h exp %h", alist[k], got, exp);
            end
        end
    endtask

    task automatic test_last_word();
        logic [33:0] exp;
        logic [33:0] got;
        do_write(32'h3FC, 32'hDEAD_BEEF);
        addr = 32'h3FC; #1;
        exp = {32'hDEAD_BEEF, 2'b00}; got = {instr, misaligned, out_of_range};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL last_word_write: got %h exp %h", got, exp);
        end
        addr = 32'h0; #1;
        checks++;
        if (instr !== boot[0]) begin
            errors++;
            $display("FAIL last_word_no_wrap: got %h exp %h", instr, boot[0]);
        end
        do_write(32'h3FE, 32'h1111_2222);
        do_write(32'h400, 32'h3333_4444);
        for (int i = 0; i < int'(DEPTH); i++) begin
            addr = 32'(i * 4); #1;
            exp = model_read(addr); got = {instr, misaligned, out_of_range};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL dropped_write_w%0d: got %h exp %h", i, got, exp);
            end
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] old_w;
        logic [31:0] new_w;
        old_w = model[4];
        new_w = $urandom;
        @(negedge clk);
        addr = 32'h10; we = 1'b1; waddr = 32'h10; wdata = new_w;
        #1;
        checks++;
        if (instr !== old_w) begin
            errors++;
            $display("FAIL same_addr_before: got %h exp %h", instr, old_w);
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        model_write(32'h10, new_w);
        checks++;
        if (instr !== new_w) begin
            errors++;
            $display("FAIL same_addr_after: got %h exp %h", instr, new_w);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [33:0] exp;
        logic [33:0] got;
        for (int n = 0; n < 300; n++) begin
            d = $urandom;
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'($urandom_range(0, DEPTH - 1) * 4);
                3:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                4:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
                default: a = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) do_write(a, d);
            if ($urandom_range(0, 3) == 0) addr = $urandom;
            else addr = 32'($urandom_range(0, DEPTH - 1) * 4 + (($urandom_range(0, 4) == 0) ? 1 : 0));
            #1;
            exp = model_read(addr); got = {instr, misaligned, out_of_range};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_read_%0d addr %h: got %h exp %h", n, addr, got, exp);
            end
        end
    endtask

    task automatic test_async_reset();
        do_write(32'h4, 32'h1234_5678);
        addr = 32'h4; #1;
        checks++;
        if (instr !== 32'h1234_5678) begin
            errors++;
            $display("FAIL async_pre_reset: got %h exp %h", instr, 32'h1234_5678);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (instr !== boot[1]) begin
            errors++;
            $display("FAIL async_reset_restore: got %h exp %h", instr, boot[1]);
        end
        addr = 32'h3FC; #1;
        checks++;
        if (instr !== NOP) begin
            errors++;
            $display("FAIL async_reset_last: got %h exp %h", instr, NOP);
        end
        addr = 32'h7; #1;
        checks++;
        if ({misaligned, out_of_range} !== 2'b10) begin
            errors++;
            $display("FAIL flags_in_reset: got %b exp %b", {misaligned, out_of_range}, 2'b10);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_we_during_reset();
        @(negedge clk);
        rst = 1'b1; we = 1'b1; waddr = 32'h0; wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        model_reset();
        addr = 32'h0; #1;
        checks++;
        if (instr !== boot[0]) begin
            errors++;
            $display("FAIL we_during_reset: got %h exp %h", instr, boot[0]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        boot = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h4011_0233,
                 32'h0020_F2B3, 32'h0020_E333, 32'h0030_2023, 32'h0000_2383};
        test_reset();
        test_flags();
        test_last_word();
        test_same_addr();
        test_random();
        test_async_reset();
        test_we_during_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
